// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze sequencing for the 5-stage MIPS core
module hazard_ctrl #(
    parameter int FLUSH_DEPTH = 1,
    parameter int MAX_WAIT    = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic [4:0]       IDEX_rt,
    input  logic             IDEX_memRead,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_HOLD  = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    // Wide enough to hold MAX_WAIT+1 for the largest legal MAX_WAIT.
    localparam int                WAIT_W     = 17;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT + 1);
    localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_t            state_q, state_d;
    state_t            saved_q, saved_d;
    state_t            eff_state;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              timeout_q, timeout_d;
    logic              stall_inc, flush_inc;
    logic              hz;

    assign hz = IDEX_memRead && (IDEX_rt != 5'd0) &&
                ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));

    // After a freeze the interrupted state is evaluated as if it had never left.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        state_d    = state_q;
        saved_d    = saved_q;
        fcnt_d     = fcnt_q;
        wcnt_d     = '0;
        timeout_d  = timeout_q;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        idex_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            stall_inc  = 1'b1;
            wcnt_d     = (wcnt_q == WAIT_LIMIT) ? wcnt_q : wcnt_q + WAIT_W'(1);
            if (wcnt_d == WAIT_LIMIT) begin
                timeout_d = 1'b1;
            end
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                saved_d = state_q;
            end
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                state_d = FLUSH;
                fcnt_d  = FLUSH_LOAD;
            end else begin
                state_d = RUN;
                fcnt_d  = 3'd0;
            end
        end else if (eff_state == FLUSH) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            fcnt_d     = fcnt_q - 3'd1;
            state_d    = (fcnt_d == 3'd0) ? RUN : FLUSH;
        end else if ((eff_state == RUN) && hz) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
            state_d    = LU_HOLD;
        end else begin
            state_d = RUN;
        end

        stall_d = (stall_inc && (stall_q != CNT_MAX)) ? stall_q + CNT_W'(1) : stall_q;
        flush_d = (flush_inc && (flush_q != CNT_MAX)) ? flush_q + CNT_W'(1) : flush_q;

        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            saved_q   <= RUN;
            fcnt_q    <= 3'd0;
            wcnt_q    <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            fcnt_q    <= fcnt_d;
            wcnt_q    <= wcnt_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            timeout_q <= timeout_d;
        end
    end

    assign state_o      = state_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;

    localparam logic [4:0] C_RST    = 5'b00011;
    localparam logic [4:0] C_FREEZE = 5'b00000;
    localparam logic [4:0] C_NORM   = 5'b11100;
    localparam logic [4:0] C_STALL  = 5'b00101;
    localparam logic [4:0] C_FLUSH  = 5'b11111;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  IFID_rs, IFID_rt, IDEX_rt;
    logic        IDEX_memRead, branch_taken, mem_busy;
    logic        pc_write, ifid_write, idex_write, ifid_flush, idex_flush;
    logic [1:0]  state_o;
    logic [15:0] stall_cycles, flush_events;
    logic        mem_timeout;
    logic        s_pc_write, s_ifid_write, s_idex_write, s_ifid_flush, s_idex_flush;
    logic [1:0]  s_state_o;
    logic [1:0]  s_stall_cycles, s_flush_events;
    logic        s_mem_timeout;

    typedef struct {
        logic [4:0]  ctrl;
        logic [1:0]  st;
        logic [15:0] stall;
        logic [15:0] flush;
        logic        to;
        logic        sat;
        logic [1:0]  sstall;
        logic [1:0]  sflush;
        logic        sto;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic       sat_en = 1'b0;
    logic [1:0] sat_stall, sat_flush;
    logic       sat_to;

    always #5 clock = ~clock;

    hazard_ctrl #(.FLUSH_DEPTH(3), .MAX_WAIT(4), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
        .IDEX_rt(IDEX_rt), .IDEX_memRead(IDEX_memRead), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .state_o(state_o), .stall_cycles(stall_cycles), .flush_events(flush_events),
        .mem_timeout(mem_timeout)
    );

    hazard_ctrl #(.FLUSH_DEPTH(1), .MAX_WAIT(4), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
        .IDEX_rt(IDEX_rt), .IDEX_memRead(IDEX_memRead), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .idex_write(s_idex_write), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .state_o(s_state_o), .stall_cycles(s_stall_cycles), .flush_events(s_flush_events),
        .mem_timeout(s_mem_timeout)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle is an output cycle; compare mid-cycle on the falling edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ctrl", {11'd0, pc_write, ifid_write, idex_write, ifid_flush, idex_flush},
                  {11'd0, e.ctrl});
            check("state", {14'd0, state_o}, {14'd0, e.st});
            check("stall_cycles", stall_cycles, e.stall);
            check("flush_events", flush_events, e.flush);
            check("mem_timeout", {15'd0, mem_timeout}, {15'd0, e.to});
            if (e.sat) begin
                check("sat_stall", {14'd0, s_stall_cycles}, {14'd0, e.sstall});
                check("sat_flush", {14'd0, s_flush_events}, {14'd0, e.sflush});
                check("sat_timeout", {15'd0, s_mem_timeout}, {15'd0, e.sto});
            end
            cyc++;
        end
    end

    task automatic drive(input logic rst, input logic busy, input logic br, input logic mr,
                         input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt);
        reset        = rst;
        mem_busy     = busy;
        branch_taken = br;
        IDEX_memRead = mr;
        IDEX_rt      = xrt;
        IFID_rs      = rs;
        IFID_rt      = rt;
    endtask

    task automatic step(input logic rst, input logic busy, input logic br, input logic mr,
                        input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] ctrl, input logic [1:0] st,
                        input logic [15:0] stall, input logic [15:0] flush, input logic to);
        exp_t e;
        drive(rst, busy, br, mr, xrt, rs, rt);
        e.ctrl = ctrl; e.st = st; e.stall = stall; e.flush = flush; e.to = to;
        e.sat = sat_en; e.sstall = sat_stall; e.sflush = sat_flush; e.sto = sat_to;
        exp_q.push_back(e);
        sat_en = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        //   rst busy br mr xrt rs rt : ctrl st stall flush to
        drive(1, 1, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_RST,    2'd0,  0, 0, 0);
        step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_RST,    2'd0,  0, 0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_NORM,   2'd0,  0, 0, 0);
        // load-use on rs, then on rt; rt==0 load never stalls
        step(0, 0, 0, 1, 5'd5, 5'd5, 5'd1, C_STALL,  2'd0,  0, 0, 0);
        step(0, 0, 0, 1, 5'd5, 5'd5, 5'd1, C_NORM,   2'd1,  1, 0, 0);
        step(0, 0, 0, 0, 5'd5, 5'd5, 5'd1, C_NORM,   2'd0,  1, 0, 0);
        step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, C_NORM,   2'd0,  1, 0, 0);
        step(0, 0, 0, 1, 5'd7, 5'd2, 5'd7, C_STALL,  2'd0,  1, 0, 0);
        step(0, 0, 0, 0, 5'd7, 5'd2, 5'd7, C_NORM,   2'd1,  2, 0, 0);
        // single branch: three flush cycles
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, C_FLUSH,  2'd0,  2, 0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_FLUSH,  2'd2,  2, 1, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_FLUSH,  2'd2,  2, 1, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_NORM,   2'd0,  2, 1, 0);
        // re-branch in second flush cycle: four flush cycles
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, C_FLUSH,  2'd0,  2, 1, 0);
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, C_FLUSH,  2'd2,  2, 2, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_FLUSH,  2'd2,  2, 3, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_FLUSH,  2'd2,  2, 3, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_NORM,   2'd0,  2, 3, 0);
        // branch beats hazard, flush-in-progress beats hazard
        step(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, C_FLUSH,  2'd0,  2, 3, 0);
        step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, C_FLUSH,  2'd2,  2, 4, 0);
        // freeze with flush counter at 1, then one residual flush
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FREEZE, 2'd2,  2, 4, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FREEZE, 2'd3,  3, 4, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FREEZE, 2'd3,  4, 4, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FREEZE, 2'd3,  5, 4, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_FLUSH,  2'd3,  6, 4, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_NORM,   2'd0,  6, 4, 0);
        // six busy cycles: timeout raised at fifth busy edge and stays sticky
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FREEZE, 2'd0,  6, 4, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FREEZE, 2'd3,  7, 4, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FREEZE, 2'd3,  8, 4, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FREEZE, 2'd3,  9, 4, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FREEZE, 2'd3, 10, 4, 0);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, C_FREEZE, 2'd3, 11, 4, 1);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_NORM,   2'd3, 12, 4, 1);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_NORM,   2'd0, 12, 4, 1);
        // reset in the middle of a flush; 2-bit counters have saturated at 3
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, C_FLUSH,  2'd0, 12, 4, 1);
        sat_en = 1'b1; sat_stall = 2'd3; sat_flush = 2'd3; sat_to = 1'b1;
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_RST,    2'd2, 12, 5, 1);
        sat_en = 1'b1; sat_stall = 2'd0; sat_flush = 2'd0; sat_to = 1'b0;
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, C_NORM,   2'd0,  0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clock);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives write-enable and flush controls for PC, IF/ID and ID/EX:
  - load-use stall with bubble insertion into ID/EX;
  - taken-branch flush;
  - full-pipeline freeze while data memory is busy.
- Keeps saturating stall/flush statistics and a sticky memory-timeout flag.

Parameters:
- FLUSH_DEPTH, 1, cycles the IF/ID and ID/EX flush is held after a taken branch (1..7).
- MAX_WAIT, 255, consecutive mem_busy cycles tolerated before mem_timeout is set (1..65535).
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- IFID_rs  in  5  rs field of the instruction in ID.
- IFID_rt  in  5  rt field of the instruction in ID.
- IDEX_rt  in  5  destination rt of the instruction in EX.
- IDEX_memRead  in  1  EX instruction is a load.
- branch_taken  in  1  branch resolved taken this cycle.
- mem_busy  in  1  data memory not ready; pipeline must hold.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- idex_write  out  1  ID/EX load enable.
- ifid_flush  out  1  IF/ID clears to zero at the next edge.
- idex_flush  out  1  ID/EX clears to zero at the next edge (bubble).
- state_o  out  2  current FSM state (debug).
- stall_cycles  out  CNT_W  load-use plus memory stall cycles, saturating.
- flush_events  out  CNT_W  taken-branch flushes, saturating.
- mem_timeout  out  1  sticky; set when mem_busy lasts more than MAX_WAIT cycles.

Behaviour:
- Single clock domain. Control outputs are combinational from state and inputs; state and counters are registered.
- Reset, any cycle including mid-flush or mid-wait:
  - next state RUN;
  - counters and mem_timeout = 0, flush counter and wait counter = 0;
  - while reset=1: pc_write=ifid_write=idex_write=0, ifid_flush=idex_flush=1.
- States: RUN=0, LU_HOLD=1, FLUSH=2, MEM_WAIT=3.
- Hazard term: hz = IDEX_memRead && IDEX_rt!=0 && (IDEX_rt==IFID_rs || IDEX_rt==IFID_rt).
- Priority each cycle: mem_busy > branch_taken > flush-in-progress > hz.
- mem_busy=1, any state:
  - all three write enables 0, both flushes 0 (freeze);
  - stall_cycles +1;
  - wait counter +1, and mem_timeout set when the counter reaches MAX_WAIT+1;
  - next state MEM_WAIT, with the prior state's residual flush count preserved.
- mem_busy falls: the wait counter clears and the saved state resumes on the next cycle. Frozen inputs are re-evaluated then.
- branch_taken=1 (mem_busy=0):
  - pc_write=1, ifid_write=1, idex_write=1, ifid_flush=1, idex_flush=1;
  - flush_events +1;
  - if FLUSH_DEPTH>1: next state FLUSH with the counter loaded to FLUSH_DEPTH-1; otherwise next state RUN.
- FLUSH: same outputs as the branch cycle; counter -1; RUN when the counter reaches 0. A new branch_taken reloads the counter and increments flush_events again.
- hz in RUN:
  - pc_write=0, ifid_write=0, idex_write=1, idex_flush=1, ifid_flush=0;
  - stall_cycles +1; next state LU_HOLD.
- LU_HOLD: hz ignored (the bubble is in EX); normal outputs; next state RUN. Exactly one stall cycle per load-use.
- Normal outputs: pc_write=ifid_write=idex_write=1, flushes 0.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- hz with IDEX_rt=0 never stalls.

Test Plan:
- Reset held for 3 cycles with mem_busy=1 -> state_o=0, counters 0, mem_timeout=0; flushes=1 and enables=0 during reset.
- IDEX_memRead=1, IDEX_rt=5, IFID_rs=5 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1, then normal; stall_cycles=1. Repeat with IDEX_rt=0 -> no stall.
- FLUSH_DEPTH=3, branch_taken pulse 1 cycle -> ifid_flush=idex_flush=1 for exactly 3 cycles; flush_events=1. A second pulse in the 2nd cycle -> 4 total flush cycles, flush_events=2.
- branch_taken and hz in the same cycle -> flush outputs only; stall_cycles unchanged.
- mem_busy high for 4 cycles during FLUSH (counter=1) -> enables 0 for 4 cycles, stall_cycles=4; then 1 more flush cycle, then RUN.
- MAX_WAIT=4, mem_busy high 6 cycles -> mem_timeout=1 from the 5th busy cycle edge and stays 1 after busy drops, until reset. Preload the counters near saturation -> they hold at 0xFFFF.
